spi_operand_assembler: RTL and testbench

SPI_OPERAND_ASSEMBLER -- requirements
Module: spi_operand_assembler

---
 rtl/spi_operand_assembler.sv | 184 ++++++++++++++++++
 tb/tb_spi_operand_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_operand_assembler.sv
// spi_operand_assembler: turns a byte stream (HEADER, NB payload bytes,
// optional checksum) into packed operands and an opcode held for a consumer.
// Ports: clk, reset (sync, active high); byte_valid/byte_in (received byte);
//   operands/opcode/out_valid with out_ready (held output frame);
//   frame_err (abort pulse), overrun (dropped-frame pulse).
// Build option: define SPI_ASM_CHECKSUM_EN for a trailing XOR checksum byte.
module spi_operand_assembler #(
  parameter int unsigned OP_WIDTH    = 4,
  parameter int unsigned NUM_OPS     = 2,
  parameter int unsigned OPC_WIDTH   = 4,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_in,
  output logic [NUM_OPS*OP_WIDTH-1:0]          operands,
  output logic [((OPC_WIDTH>0)?OPC_WIDTH:1)-1:0] opcode,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 frame_err,
  output logic                                 overrun
);

  localparam int unsigned OW  = NUM_OPS * OP_WIDTH;
  localparam int unsigned P   = OW + OPC_WIDTH;
  localparam int unsigned NB  = (P + 7) / 8;
  localparam int unsigned PB  = NB * 8;
  localparam int unsigned OCW = (OPC_WIDTH > 0) ? OPC_WIDTH : 1;
  localparam int unsigned CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IW  = $clog2(TIMEOUT_CYC + 1);

`ifdef SPI_ASM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [PB-1:0]   buf_q, buf_d;
  logic [PB-1:0]   frame_w;
  logic            done, tmo;
  logic [OW-1:0]   ops_q, ops_d;
  logic [OCW-1:0]  opc_q, opc_d, new_opc;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;
`ifdef SPI_ASM_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  // Padding bits above the payload are received but carry no meaning.
  logic unused_pad;
  assign unused_pad = ^frame_w;

  assign tmo = !byte_valid && (idle_q == IW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    frame_w = buf_q;
    done    = 1'b0;
    err_d   = 1'b0;
`ifdef SPI_ASM_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    if (state_q == S_IDLE || byte_valid) idle_d = '0;
    else                                 idle_d = idle_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (byte_valid && byte_in == HEADER) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
`ifdef SPI_ASM_CHECKSUM_EN
          chk_d   = HEADER;
`endif
        end
      end
      S_PAYLOAD: begin
        if (byte_valid) begin
          for (int i = 0; i < NB; i++)
            if (cnt_q == CW'(i)) buf_d[i*8 +: 8] = byte_in;
          cnt_d = cnt_q + 1'b1;
`ifdef SPI_ASM_CHECKSUM_EN
          chk_d = chk_q ^ byte_in;
`endif
          if (cnt_q == CW'(NB - 1)) begin
            cnt_d = '0;
`ifdef SPI_ASM_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
            done    = 1'b1;
            frame_w = buf_d;
`endif
          end
        end else if (tmo) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
`ifdef SPI_ASM_CHECKSUM_EN
      S_CHECK: begin
        if (byte_valid) begin
          state_d = S_IDLE;
          if (byte_in == chk_q) done  = 1'b1;
          else                  err_d = 1'b1;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  if (OPC_WIDTH > 0) begin : g_opc
    assign new_opc = frame_w[OW +: OCW];
  end else begin : g_noopc
    assign new_opc = '0;
  end

  // Output holding register: only completion and the handshake touch it.
  always_comb begin
    ops_d = ops_q;
    opc_d = opc_q;
    vld_d = vld_q;
    ovr_d = 1'b0;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (done) begin
      if (!vld_q || out_ready) begin
        ops_d = frame_w[OW-1:0];
        opc_d = new_opc;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      buf_q   <= '0;
      ops_q   <= '0;
      opc_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SPI_ASM_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      buf_q   <= buf_d;
      ops_q   <= ops_d;
      opc_q   <= opc_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
`ifdef SPI_ASM_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign operands  = ops_q;
  assign opcode    = opc_q;
  assign out_valid = vld_q;
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_operand_assembler.sv
// Bench for spi_operand_assembler: directed scenarios plus random bytes,
// compared cycle by cycle against a frame-level reference model.
module tb_spi_operand_assembler;

  localparam int         OPW  = 4;
  localparam int         NOPS = 2;
  localparam int         OPCW = 4;
  localparam int         TMO  = 1000;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         OW   = OPW * NOPS;
  localparam int         NB   = (OW + OPCW + 7) / 8;
`ifdef SPI_ASM_CHECKSUM_EN
  localparam int         FB   = NB + 1;
`else
  localparam int         FB   = NB;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic [OW-1:0] operands;
  logic [OPCW-1:0] opcode;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  spi_operand_assembler #(
    .OP_WIDTH(OPW), .NUM_OPS(NOPS), .OPC_WIDTH(OPCW),
    .HEADER(HDR), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_in(byte_in),
    .operands(operands), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: frame-level view of the byte stream.
  logic            m_in;
  logic [7:0]      m_q[$];
  int              m_idle;
  logic            m_vld;
  logic [OW-1:0]   m_ops;
  logic [OPCW-1:0] m_opc;
  logic            m_err;
  logic            m_ovr;

  task automatic model_step(input logic rst, input logic bv,
                            input logic [7:0] b, input logic rdy);
    logic        done;
    logic        old;
    int unsigned val;
    logic [7:0]  x;
    done  = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (rst) begin
      m_in = 1'b0; m_q.delete(); m_idle = 0;
      m_vld = 1'b0; m_ops = '0; m_opc = '0;
      return;
    end
    if (bv) begin
      m_idle = 0;
      if (!m_in) begin
        if (b == HDR) begin m_in = 1'b1; m_q.delete(); end
      end else begin
        m_q.push_back(b);
        if (m_q.size() == FB) begin
          m_in = 1'b0;
          done = 1'b1;
          x = HDR;
          for (int i = 0; i < NB; i++) x = x ^ m_q[i];
          if (FB > NB && m_q[FB-1] != x) begin
            done = 1'b0; m_err = 1'b1;
          end
        end
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_in = 1'b0; m_err = 1'b1; m_idle = 0;
      end
    end
    old = m_vld;
    if (old && rdy) m_vld = 1'b0;
    if (done) begin
      if (!old || rdy) begin
        val = 0;
        for (int i = 0; i < NB; i++) val = val | (int'(m_q[i]) << (8 * i));
        m_ops = OW'(val);
        m_opc = OPCW'(val >> OW);
        m_vld = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic bv,
                      input logic [7:0] b, input logic rdy);
    reset = rst; byte_valid = bv; byte_in = b; out_ready = rdy;
    model_step(rst, bv, b, rdy);
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("operands",  32'(operands),  32'(m_ops));
    chk("opcode",    32'(opcode),    32'(m_opc));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic rdy_last);
    step(1'b0, 1'b1, HDR, 1'b0);
    step(1'b0, 1'b1, b1, 1'b0);
`ifdef SPI_ASM_CHECKSUM_EN
    step(1'b0, 1'b1, b2, 1'b0);
    step(1'b0, 1'b1, HDR ^ b1 ^ b2, rdy_last);
`else
    step(1'b0, 1'b1, b2, rdy_last);
`endif
  endtask

  initial begin
    int tmo_at;
    reset = 1'b1; byte_valid = 1'b0; byte_in = '0; out_ready = 1'b0;
    step(1'b1, 1'b1, HDR, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ops",   32'(operands),  32'd0);

    // basic frame, output held
    send_frame(8'h21, 8'h03, 1'b0);
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_ops",   32'(operands),  32'h21);
    chk("f1_opc",   32'(opcode),    32'h3);

    // second frame while held -> overrun, data kept
    send_frame(8'h54, 8'h07, 1'b0);
    chk("ovr_pulse", 32'(overrun),  32'd1);
    chk("ovr_ops",   32'(operands), 32'h21);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_clear", 32'(out_valid), 32'd0);

    // leading junk, header as data, accept in completion cycle
    send_frame(8'h21, 8'h03, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b1, HDR, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
`ifdef SPI_ASM_CHECKSUM_EN
    step(1'b0, 1'b1, 8'h0C, 1'b0);
    step(1'b0, 1'b1, HDR ^ 8'hA5 ^ 8'h0C, 1'b1);
`else
    step(1'b0, 1'b1, 8'h0C, 1'b1);
`endif
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_ops",   32'(operands),  32'hA5);
    chk("swap_opc",   32'(opcode),    32'hC);
    chk("swap_ovr",   32'(overrun),   32'd0);

    // timeout mid-frame, then a clean frame
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, HDR, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    tmo_at = -1;
    for (int i = 0; i < TMO + 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1 && tmo_at < 0) tmo_at = i;
    end
    chk("tmo_cycle", 32'(tmo_at), 32'(TMO - 1));
    send_frame(8'h43, 8'h01, 1'b0);
    chk("post_tmo_ops", 32'(operands), 32'h43);
    chk("post_tmo_opc", 32'(opcode),   32'h1);

`ifdef SPI_ASM_CHECKSUM_EN
    step(1'b0, 1'b0, 8'h00, 1'b1);
    send_frame(8'h21, 8'h03, 1'b1);
    chk("cs_ok_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, HDR, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    step(1'b0, 1'b1, 8'h88, 1'b0);
    chk("cs_bad_err",   32'(frame_err), 32'd1);
    chk("cs_bad_valid", 32'(out_valid), 32'd0);
`endif

    // reset mid-frame, stray byte afterwards
    step(1'b0, 1'b0, 8'h00, 1'b1);
    send_frame(8'h21, 8'h03, 1'b0);
    step(1'b0, 1'b1, HDR, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ops",   32'(operands),  32'd0);
    chk("mid_rst_err",   32'(frame_err), 32'd0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    chk("stray_valid", 32'(out_valid), 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic       r_bv, r_rdy, r_rst;
      logic [7:0] r_b;
      r_bv  = ($urandom_range(0, 2) != 0);
      r_b   = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
      r_rdy = ($urandom_range(0, 3) == 0);
      r_rst = ($urandom_range(0, 499) == 0);
      step(r_rst, r_bv, r_b, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
